// File: rtl/player_move_if.sv
// Wall-memory read port between player_move (master) and the maze wall RAM (slave).
// wall_hit is valid the cycle after wall_rd.
interface player_move_if #(
   parameter int unsigned COORD_W = 4
);
   logic               wall_rd;
   logic [COORD_W-1:0] wall_x;
   logic [COORD_W-1:0] wall_y;
   logic               wall_hit;

   modport master (output wall_rd, output wall_x, output wall_y, input wall_hit);
   modport slave  (input wall_rd, input wall_x, input wall_y, output wall_hit);
endinterface

// File: rtl/player_move.sv
// Grid-movement controller for the maze player: heading, cell position, and
// wall-checked forward steps through a one-cycle-latency wall read port.
// Optional feature: define PLAYER_REPEAT_EN to auto-repeat a held command every
// REPEAT_CYCLES idle cycles.
module player_move #(
   parameter int unsigned MAZE_W        = 16,
   parameter int unsigned MAZE_H        = 16,
   parameter int unsigned COORD_W       = 4,
   parameter int unsigned START_X       = 0,
   parameter int unsigned START_Y       = 0,
   parameter int unsigned GOAL_X        = 15,
   parameter int unsigned GOAL_Y        = 15,
   parameter int unsigned REPEAT_CYCLES = 25_000_000
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [1:0]         cmd,
   player_move_if.master      wall,
   output logic [COORD_W-1:0] pos_x,
   output logic [COORD_W-1:0] pos_y,
   output logic [1:0]         heading,
   output logic               moved,
   output logic               blocked,
   output logic               busy,
   output logic               at_goal
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StTurn  = 3'd1;
   localparam logic [2:0] StQuery = 3'd2;
   localparam logic [2:0] StWait  = 3'd3;
   localparam logic [2:0] StDone  = 3'd4;

   if ((1 << COORD_W) < MAZE_W || (1 << COORD_W) < MAZE_H || REPEAT_CYCLES == 0)
   begin : g_bad_param
      $error("player_move: illegal parameter set");
   end

   logic [2:0]         state_q, state_d;
   logic [1:0]         heading_q, heading_d;
   logic [COORD_W-1:0] pos_x_q, pos_x_d, pos_y_q, pos_y_d;
   logic [1:0]         last_cmd_q, last_cmd_d;
   logic [COORD_W-1:0] tgt_x_q, tgt_x_d, tgt_y_q, tgt_y_d;
   logic               oob_q, oob_d;
   logic               moved_q, moved_d, blocked_q, blocked_d;
   logic               at_goal_q, at_goal_d;
   logic               wall_rd_q, wall_rd_d;
   logic [COORD_W-1:0] wall_x_q, wall_x_d, wall_y_q, wall_y_d;

   logic               rpt_fire;
   logic               accept;
   logic [COORD_W-1:0] nx, ny;
   logic               step_oob;

`ifdef PLAYER_REPEAT_EN
   localparam int unsigned RptW = ($clog2(REPEAT_CYCLES) > 25) ? $clog2(REPEAT_CYCLES) : 25;

   logic [RptW-1:0] rpt_q, rpt_d;

   // Count idle cycles with a held, non-zero command; fire and clear at the period end.
   always_comb begin
      rpt_d    = rpt_q;
      rpt_fire = 1'b0;
      if (state_q == StIdle) begin
         if (cmd == last_cmd_q && cmd != 2'd0 && !at_goal_q) begin
            if (rpt_q == RptW'(REPEAT_CYCLES - 1)) begin
               rpt_fire = 1'b1;
               rpt_d    = '0;
            end else begin
               rpt_d = rpt_q + RptW'(1);
            end
         end else begin
            rpt_d = '0;
         end
      end
   end

   // Repeat counter register; holds while busy (it was cleared on acceptance).
   always_ff @(posedge clk) begin
      if (rst) rpt_q <= '0;
      else     rpt_q <= rpt_d;
   end
`else
   assign rpt_fire = 1'b0;
`endif

   assign accept = (state_q == StIdle) && !at_goal_q && (cmd != 2'd0) &&
                   ((cmd != last_cmd_q) || rpt_fire);

   // Forward target cell; bounds are checked before any add/subtract so nothing wraps.
   always_comb begin
      nx       = pos_x_q;
      ny       = pos_y_q;
      step_oob = 1'b0;
      unique case (heading_q)
         2'd0: if (pos_y_q == '0) step_oob = 1'b1;
               else ny = pos_y_q - COORD_W'(1);
         2'd1: if (pos_x_q == COORD_W'(MAZE_W - 1)) step_oob = 1'b1;
               else nx = pos_x_q + COORD_W'(1);
         2'd2: if (pos_y_q == COORD_W'(MAZE_H - 1)) step_oob = 1'b1;
               else ny = pos_y_q + COORD_W'(1);
         2'd3: if (pos_x_q == '0) step_oob = 1'b1;
               else nx = pos_x_q - COORD_W'(1);
         default: ;
      endcase
   end

   // Next-state logic for the move FSM and its datapath.
   always_comb begin
      state_d    = state_q;
      heading_d  = heading_q;
      pos_x_d    = pos_x_q;
      pos_y_d    = pos_y_q;
      last_cmd_d = last_cmd_q;
      tgt_x_d    = tgt_x_q;
      tgt_y_d    = tgt_y_q;
      oob_d      = oob_q;
      moved_d    = 1'b0;
      blocked_d  = 1'b0;
      at_goal_d  = at_goal_q;
      wall_rd_d  = 1'b0;
      wall_x_d   = wall_x_q;
      wall_y_d   = wall_y_q;
      unique case (state_q)
         StIdle: begin
            last_cmd_d = cmd;
            if (accept) begin
               case (cmd)
                  2'd1: begin
                     state_d = StQuery;
                     tgt_x_d = nx;
                     tgt_y_d = ny;
                     oob_d   = step_oob;
                     if (!step_oob) begin
                        wall_rd_d = 1'b1;
                        wall_x_d  = nx;
                        wall_y_d  = ny;
                     end
                  end
                  2'd2: begin
                     state_d   = StTurn;
                     heading_d = heading_q + 2'd3;
                  end
                  2'd3: begin
                     state_d   = StTurn;
                     heading_d = heading_q + 2'd1;
                  end
                  default: ;
               endcase
            end
         end
         StTurn:  state_d = StIdle;
         StQuery: state_d = StWait;
         StWait: begin
            state_d = StDone;
            if (oob_q || wall.wall_hit) begin
               blocked_d = 1'b1;
            end else begin
               pos_x_d = tgt_x_q;
               pos_y_d = tgt_y_q;
               moved_d = 1'b1;
            end
         end
         StDone: begin
            state_d = StIdle;
            if (pos_x_q == COORD_W'(GOAL_X) && pos_y_q == COORD_W'(GOAL_Y)) at_goal_d = 1'b1;
         end
         default: state_d = StIdle;
      endcase
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         heading_q  <= 2'd0;
         pos_x_q    <= COORD_W'(START_X);
         pos_y_q    <= COORD_W'(START_Y);
         last_cmd_q <= 2'd0;
         tgt_x_q    <= '0;
         tgt_y_q    <= '0;
         oob_q      <= 1'b0;
         moved_q    <= 1'b0;
         blocked_q  <= 1'b0;
         at_goal_q  <= 1'b0;
         wall_rd_q  <= 1'b0;
         wall_x_q   <= '0;
         wall_y_q   <= '0;
      end else begin
         state_q    <= state_d;
         heading_q  <= heading_d;
         pos_x_q    <= pos_x_d;
         pos_y_q    <= pos_y_d;
         last_cmd_q <= last_cmd_d;
         tgt_x_q    <= tgt_x_d;
         tgt_y_q    <= tgt_y_d;
         oob_q      <= oob_d;
         moved_q    <= moved_d;
         blocked_q  <= blocked_d;
         at_goal_q  <= at_goal_d;
         wall_rd_q  <= wall_rd_d;
         wall_x_q   <= wall_x_d;
         wall_y_q   <= wall_y_d;
      end
   end

   assign pos_x        = pos_x_q;
   assign pos_y        = pos_y_q;
   assign heading      = heading_q;
   assign moved        = moved_q;
   assign blocked      = blocked_q;
   assign at_goal      = at_goal_q;
   assign busy         = (state_q != StIdle);
   assign wall.wall_rd = wall_rd_q;
   assign wall.wall_x  = wall_x_q;
   assign wall.wall_y  = wall_y_q;

endmodule

// File: tb/tb_player_move.sv
// Directed bench for player_move: reset, turns, wall/clear/boundary steps, goal lock,
// reset mid-query and (with PLAYER_REPEAT_EN) auto-repeat with REPEAT_CYCLES=8.
module tb_player_move;

   logic       clk;
   logic       rst;
   logic [1:0] cmd;
   logic [3:0] pos_x, pos_y;
   logic [1:0] heading;
   logic       moved, blocked, busy, at_goal;

   int checks = 0;
   int errors = 0;

   player_move_if #(.COORD_W(4)) wall_bus ();

   player_move #(
      .MAZE_W(16), .MAZE_H(16), .COORD_W(4), .START_X(0), .START_Y(0),
      .GOAL_X(15), .GOAL_Y(15), .REPEAT_CYCLES(8)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .cmd     (cmd),
      .wall    (wall_bus),
      .pos_x   (pos_x),
      .pos_y   (pos_y),
      .heading (heading),
      .moved   (moved),
      .blocked (blocked),
      .busy    (busy),
      .at_goal (at_goal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic turn(input logic [1:0] c);
      cmd = 2'd0;
      tick(1);
      cmd = c;
      tick(2);
   endtask

   task automatic step();
      cmd = 2'd0;
      tick(1);
      cmd = 2'd1;
      tick(4);
   endtask

   initial begin
      rst = 1'b1;
      cmd = 2'd0;
      wall_bus.wall_hit = 1'b0;
      tick(2);
      check("rst_pos_x", 32'(pos_x), 0);
      check("rst_pos_y", 32'(pos_y), 0);
      check("rst_heading", 32'(heading), 0);
      check("rst_moved", 32'(moved), 0);
      check("rst_blocked", 32'(blocked), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_at_goal", 32'(at_goal), 0);
      check("rst_wall_rd", 32'(wall_bus.wall_rd), 0);
      check("rst_wall_x", 32'(wall_bus.wall_x), 0);
      check("rst_wall_y", 32'(wall_bus.wall_y), 0);
      rst = 1'b0;

      // North boundary at (0,0)
      cmd = 2'd1;
      tick(1);
      check("bnd_n_wall_rd", 32'(wall_bus.wall_rd), 0);
      check("bnd_n_busy", 32'(busy), 1);
      tick(2);
      check("bnd_n_blocked", 32'(blocked), 1);
      check("bnd_n_moved", 32'(moved), 0);
      check("bnd_n_pos_x", 32'(pos_x), 0);
      check("bnd_n_pos_y", 32'(pos_y), 0);
      tick(1);
      check("bnd_n_blocked_end", 32'(blocked), 0);

      // Turns
      cmd = 2'd0;
      tick(1);
      cmd = 2'd3;
      tick(1);
      check("turn_r_heading", 32'(heading), 1);
      check("turn_r_busy", 32'(busy), 1);
      check("turn_r_wall_rd", 32'(wall_bus.wall_rd), 0);
      tick(1);
      check("turn_r_idle", 32'(busy), 0);
      cmd = 2'd2;
      tick(1);
      check("turn_l_heading", 32'(heading), 0);
      tick(5);
      check("turn_hold_heading", 32'(heading), 0);
      check("turn_hold_busy", 32'(busy), 0);

      // Walk to (3,3) facing east
      turn(2'd3);
      turn(2'd3);
      repeat (3) step();
      turn(2'd2);
      repeat (3) step();
      check("nav_pos_x", 32'(pos_x), 3);
      check("nav_pos_y", 32'(pos_y), 3);
      check("nav_heading", 32'(heading), 1);

      // Wall ahead
      cmd = 2'd0;
      wall_bus.wall_hit = 1'b1;
      tick(1);
      cmd = 2'd1;
      tick(1);
      check("wall_rd", 32'(wall_bus.wall_rd), 1);
      check("wall_x", 32'(wall_bus.wall_x), 4);
      check("wall_y", 32'(wall_bus.wall_y), 3);
      tick(1);
      check("wall_rd_single", 32'(wall_bus.wall_rd), 0);
      tick(1);
      check("wall_blocked", 32'(blocked), 1);
      check("wall_moved", 32'(moved), 0);
      check("wall_pos_x", 32'(pos_x), 3);
      tick(1);
      check("wall_blocked_end", 32'(blocked), 0);
      check("wall_pos_x_end", 32'(pos_x), 3);

      // Clear step; wall_hit high outside the sample cycle must be ignored
      cmd = 2'd0;
      tick(1);
      cmd = 2'd1;
      tick(1);
      check("clr_wall_rd", 32'(wall_bus.wall_rd), 1);
      tick(1);
      wall_bus.wall_hit = 1'b0;
      tick(1);
      wall_bus.wall_hit = 1'b1;
      check("clr_moved", 32'(moved), 1);
      check("clr_blocked", 32'(blocked), 0);
      check("clr_pos_x", 32'(pos_x), 4);
      check("clr_pos_y", 32'(pos_y), 3);
      tick(1);
      check("clr_moved_end", 32'(moved), 0);
      check("clr_pos_x_end", 32'(pos_x), 4);
      wall_bus.wall_hit = 1'b0;

      // East boundary at x=15
      repeat (11) step();
      cmd = 2'd0;
      tick(1);
      cmd = 2'd1;
      tick(1);
      check("bnd_e_wall_rd", 32'(wall_bus.wall_rd), 0);
      tick(2);
      check("bnd_e_blocked", 32'(blocked), 1);
      check("bnd_e_pos_x", 32'(pos_x), 15);
      tick(1);

      // Reach the goal
      turn(2'd3);
      repeat (11) step();
      check("pre_goal_pos_y", 32'(pos_y), 14);
      cmd = 2'd0;
      tick(1);
      cmd = 2'd1;
      tick(3);
      check("goal_moved", 32'(moved), 1);
      check("goal_pos_y", 32'(pos_y), 15);
      check("goal_flag_early", 32'(at_goal), 0);
      tick(1);
      check("goal_flag", 32'(at_goal), 1);
      cmd = 2'd3;
      tick(1);
      check("goal_lock_busy", 32'(busy), 0);
      tick(2);
      cmd = 2'd1;
      tick(5);
      check("goal_lock_heading", 32'(heading), 2);
      check("goal_lock_pos_x", 32'(pos_x), 15);
      check("goal_lock_pos_y", 32'(pos_y), 15);
      check("goal_lock_flag", 32'(at_goal), 1);

      // Reset in the middle of a query
      rst = 1'b1;
      cmd = 2'd0;
      tick(1);
      rst = 1'b0;
      check("rst2_at_goal", 32'(at_goal), 0);
      turn(2'd3);
      cmd = 2'd0;
      tick(1);
      cmd = 2'd1;
      tick(1);
      check("mid_wall_rd", 32'(wall_bus.wall_rd), 1);
      check("mid_wall_x", 32'(wall_bus.wall_x), 1);
      tick(1);
      rst = 1'b1;
      tick(1);
      check("mid_moved", 32'(moved), 0);
      check("mid_blocked", 32'(blocked), 0);
      check("mid_pos_x", 32'(pos_x), 0);
      check("mid_heading", 32'(heading), 0);
      check("mid_busy", 32'(busy), 0);
      rst = 1'b0;
      cmd = 2'd0;
      tick(1);
      check("mid_moved_after", 32'(moved), 0);
      check("mid_blocked_after", 32'(blocked), 0);
      check("mid_pos_x_after", 32'(pos_x), 0);

      // Held straight command on the open top row
      turn(2'd3);
      cmd = 2'd0;
      tick(1);
      cmd = 2'd1;
      tick(3);
      check("hold_first_moved", 32'(moved), 1);
      check("hold_first_pos_x", 32'(pos_x), 1);
      tick(10);
      check("hold_gap_moved", 32'(moved), 0);
      check("hold_gap_pos_x", 32'(pos_x), 1);
      tick(1);
`ifdef PLAYER_REPEAT_EN
      check("rpt_2nd_moved", 32'(moved), 1);
      check("rpt_2nd_pos_x", 32'(pos_x), 2);
      tick(11);
      check("rpt_3rd_moved", 32'(moved), 1);
      check("rpt_3rd_pos_x", 32'(pos_x), 3);
`else
      check("norpt_moved", 32'(moved), 0);
      check("norpt_pos_x", 32'(pos_x), 1);
      tick(11);
      check("norpt_pos_x_late", 32'(pos_x), 1);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
